ppu_sparse_encoder: RTL and testbench

- Post-processing encoder that produces the compressed stream the activation/output RAM consumes.
- Accepts dense output-activation beats from the accumulator path, applies optional ReLU, and zero-run-length encodes them.
- Emits packed beats of {valid mask, data, 4-bit zero-run index}, the PPU-to-OARAM format the RAM writes sequentially at its write pointer.
- Encoder counterpart of the RAM's sparse-stream write/decode side.

---
 rtl/ppu_sparse_encoder_pkg.sv | 33 +++
 rtl/ppu_sparse_encoder_lane.sv | 51 +++++
 rtl/ppu_sparse_encoder.sv | 110 +++++++++++
 tb/tb_ppu_sparse_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_sparse_encoder_pkg.sv
// Shared types and constants for the PPU sparse (zero-run-length) encoder.
// Optional feature macro: PPU_RELU_EN (clamp negative activations to zero).
package ppu_sparse_encoder_pkg;

  localparam int unsigned N_LANE             = 4;
  localparam int unsigned num_of_outputs_PPU = N_LANE;
  localparam int unsigned DW                 = 16;
  localparam int unsigned IW                 = 4;
  localparam int unsigned CNT_W              = 16;
  localparam int unsigned NW                 = $clog2(N_LANE + 1);

  typedef logic [DW-1:0] act_t;
  typedef logic [IW-1:0] run_t;

  localparam run_t RMAX = '1;

  // PPU-to-OARAM beat, entries packed from slot 0 upward.
  typedef struct packed {
    logic [num_of_outputs_PPU-1:0]                valid;
    logic [num_of_outputs_PPU-1:0][DW-1:0]        output_data;
    logic [num_of_outputs_PPU-1:0][IW-1:0]        output_indices;
  } ppu_oaram_beat_t;

  // Value as seen by the sparsity test: negatives are zeroed when ReLU is built in.
  function automatic act_t sparse_value(input act_t a);
`ifdef PPU_RELU_EN
    return a[DW-1] ? act_t'('0) : a;
`else
    return a;
`endif
  endfunction

endpackage

// File: rtl/ppu_sparse_encoder_lane.sv
// Combinational lane scan: zero-run-length encodes one dense beat given the carried run.
// Optional feature macro: PPU_RELU_EN (applied through sparse_value).
module ppu_lane_scan
  import ppu_sparse_encoder_pkg::*;
(
  input  logic [N_LANE*DW-1:0]      dense,
  input  run_t                      r_in,
  output logic [N_LANE-1:0]         mask,
  output logic [N_LANE-1:0][DW-1:0] data,
  output logic [N_LANE-1:0][IW-1:0] indices,
  output logic [NW-1:0]             count,
  output run_t                      r_out
);

  act_t        e;
  run_t        r;
  int unsigned n;

  always_comb begin
    mask    = '0;
    data    = '0;
    indices = '0;
    count   = '0;
    r_out   = '0;
    e       = '0;
    r       = r_in;
    n       = 0;
    for (int unsigned i = 0; i < N_LANE; i++) begin
      e = sparse_value(dense[i*DW +: DW]);
      // A saturated run forces an explicit entry so the run never overflows IW bits.
      if (e != '0 || r == RMAX) begin
        for (int unsigned j = 0; j < N_LANE; j++) begin
          if (j == n) begin
            data[j]    = e;
            indices[j] = r;
          end
        end
        n = n + 1;
        r = '0;
      end else begin
        r = r + 1'b1;
      end
    end
    for (int unsigned j = 0; j < N_LANE; j++) begin
      mask[j] = (j < n);
    end
    count = NW'(n);
    r_out = r;
  end

endmodule

// File: rtl/ppu_sparse_encoder.sv
// Sparse encoder top: output register, handshake, run carry and per-plane entry count.
// Optional feature macro: PPU_RELU_EN (ReLU before encoding).
module ppu_sparse_encoder
  import ppu_sparse_encoder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_LANE*DW-1:0]   in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_LANE-1:0]      out_mask,
  output logic [N_LANE*DW-1:0]   out_data,
  output logic [N_LANE*IW-1:0]   out_indices,
  output logic                   out_last,
  output logic [CNT_W-1:0]       plane_nnz,
  output logic                   plane_done
);

  logic                      alive;
  logic                      valid_q;
  logic                      last_q;
  ppu_oaram_beat_t           beat_q;
  logic [NW-1:0]             cnt_q;
  run_t                      run_q;
  logic [CNT_W-1:0]          ent_cnt;
  logic [CNT_W-1:0]          nnz_q;
  logic                      done_q;

  logic [N_LANE-1:0]         s_mask;
  logic [N_LANE-1:0][DW-1:0] s_data;
  logic [N_LANE-1:0][IW-1:0] s_idx;
  logic [NW-1:0]             s_count;
  run_t                      s_run;

  logic                      accept;
  logic                      out_fire;
  logic [CNT_W-1:0]          plane_total;

  ppu_lane_scan u_scan (
    .dense   (in_data),
    .r_in    (run_q),
    .mask    (s_mask),
    .data    (s_data),
    .indices (s_idx),
    .count   (s_count),
    .r_out   (s_run)
  );

  assign in_ready    = alive && (!valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign out_fire    = valid_q && out_ready;
  // Counting on the output side means a new plane entering while the old last beat
  // leaves can never mix counts.
  assign plane_total = ent_cnt + CNT_W'(cnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      beat_q  <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        valid_q               <= 1'b1;
        last_q                <= in_last;
        beat_q.valid          <= s_mask;
        beat_q.output_data    <= s_data;
        beat_q.output_indices <= s_idx;
        cnt_q                 <= s_count;
        run_q                 <= in_last ? run_t'('0) : s_run;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_cnt <= '0;
      nnz_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_fire) begin
        if (last_q) begin
          nnz_q   <= plane_total;
          done_q  <= 1'b1;
          ent_cnt <= '0;
        end else begin
          ent_cnt <= plane_total;
        end
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_mask    = beat_q.valid;
  assign out_data    = beat_q.output_data;
  assign out_indices = beat_q.output_indices;
  assign out_last    = last_q;
  assign plane_nnz   = nnz_q;
  assign plane_done  = done_q;

endmodule

// File: tb/tb_ppu_sparse_encoder.sv
// Directed + randomized scoreboard bench for ppu_sparse_encoder (PPU_RELU_EN aware).
module tb_ppu_sparse_encoder;
  import ppu_sparse_encoder_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [N_LANE*DW-1:0] in_data = '0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [N_LANE-1:0]    out_mask;
  logic [N_LANE*DW-1:0] out_data;
  logic [N_LANE*IW-1:0] out_indices;
  logic                 out_last;
  logic [CNT_W-1:0]     plane_nnz;
  logic                 plane_done;

  ppu_sparse_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mask    (out_mask),
    .out_data    (out_data),
    .out_indices (out_indices),
    .out_last    (out_last),
    .plane_nnz   (plane_nnz),
    .plane_done  (plane_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [63:0] data;
    logic [15:0] idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   nnz_q[$];
  int   tests = 0;
  int   fails = 0;
  int   planes_exp = 0;
  int   done_seen = 0;
  int   m_run = 0;
  int   m_cnt = 0;
  bit   rnd_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [15:0] pki(input int i0, input int i1, input int i2, input int i3);
    return {4'(i3), 4'(i2), 4'(i1), 4'(i0)};
  endfunction

  function automatic logic [63:0] dmask(input logic [3:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = {16{m[i]}};
    return r;
  endfunction

  function automatic logic [15:0] imask(input logic [3:0] m);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = {4{m[i]}};
    return r;
  endfunction

  task automatic push_exp(input logic [3:0] m, input logic [63:0] d, input logic [15:0] ix, input logic l);
    exp_t e;
    e.mask = m; e.data = d; e.idx = ix; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_nnz(input int n);
    nnz_q.push_back(n);
    planes_exp++;
  endtask

  // Reference model used for the randomized traffic.
  task automatic model_beat(input logic [63:0] d, input bit last);
    exp_t e;
    logic signed [15:0] v;
    int n;
    int r;
    n = 0; r = m_run;
    e.mask = '0; e.data = '0; e.idx = '0; e.last = last;
    for (int k = 0; k < 4; k++) begin
      v = d[k*16 +: 16];
`ifdef PPU_RELU_EN
      if (v < 0) v = '0;
`endif
      if (v != 0 || r == 15) begin
        e.data[n*16 +: 16] = v;
        e.idx[n*4 +: 4]    = 4'(r);
        e.mask[n]          = 1'b1;
        n++;
        r = 0;
      end else begin
        r++;
      end
    end
    exp_q.push_back(e);
    m_cnt += n;
    m_run = last ? 0 : r;
    if (last) begin
      push_nnz(m_cnt % 65536);
      m_cnt = 0;
    end
  endtask

  task automatic send(input logic [63:0] d, input bit last, output int waits);
    bit ok;
    in_valid = 1'b1; in_data = d; in_last = last; waits = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waits++;
      if (waits > 200) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", waits);
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || nnz_q.size() != 0) && c < 200) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (exp_q.size() != 0 || nnz_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d beats and %0d planes outstanding, required 0",
               exp_q.size(), nnz_q.size());
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   n;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_beat: mask=%0h, required no beat", out_mask);
      end else begin
        e = exp_q.pop_front();
        chk("out_mask", 64'(out_mask), 64'(e.mask));
        chk("out_data", out_data & dmask(e.mask), e.data & dmask(e.mask));
        chk("out_indices", 64'(out_indices & imask(e.mask)), 64'(e.idx & imask(e.mask)));
        chk("out_last", 64'(out_last), 64'(e.last));
      end
    end
    if (!rst && plane_done) begin
      done_seen++;
      if (nnz_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_plane_done: plane_nnz=%0d, required no pulse", plane_nnz);
      end else begin
        n = nnz_q.pop_front();
        chk("plane_nnz", 64'(plane_nnz), 64'(n));
      end
    end
  end

  initial begin
    int w;
    int w2;
    logic [63:0] d;
    bit l;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_mask", 64'(out_mask), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_indices", 64'(out_indices), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_plane_nnz", 64'(plane_nnz), 64'd0);
    chk("rst_plane_done", 64'(plane_done), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_before_clk", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_clk", 64'(in_ready), 64'd1);

    // [5,0,0,7] last
    push_exp(4'b0011, pk(5, 7, 0, 0), pki(0, 2, 0, 0), 1'b1);
    push_nnz(2);
    send(pk(5, 0, 0, 7), 1'b1, w);
    drain();

    // Run saturation: 16 zeros become an explicit {0,15}
    for (int i = 0; i < 3; i++) push_exp(4'b0000, '0, '0, 1'b0);
    push_exp(4'b0001, pk(0, 0, 0, 0), pki(15, 0, 0, 0), 1'b0);
    push_exp(4'b0001, pk(9, 0, 0, 0), pki(3, 0, 0, 0), 1'b1);
    push_nnz(2);
    for (int i = 0; i < 4; i++) send('0, 1'b0, w);
    send(pk(0, 0, 0, 9), 1'b1, w);
    drain();

    // Empty last beat
    push_exp(4'b0000, '0, '0, 1'b1);
    push_nnz(0);
    send('0, 1'b1, w);
    drain();

    // Negative values
`ifdef PPU_RELU_EN
    push_exp(4'b0001, pk(4, 0, 0, 0), pki(1, 0, 0, 0), 1'b1);
    push_nnz(1);
`else
    push_exp(4'b0111, pk(-3, 4, -1, 0), pki(0, 0, 1, 0), 1'b1);
    push_nnz(3);
`endif
    send(pk(-3, 4, 0, -1), 1'b1, w);
    drain();

    // Backpressure for 3 cycles during back-to-back traffic
    push_exp(4'b1111, pk(1, 2, 3, 4), pki(0, 0, 0, 0), 1'b0);
    push_exp(4'b0001, pk(5, 0, 0, 0), pki(1, 0, 0, 0), 1'b0);
    push_exp(4'b0001, pk(6, 0, 0, 0), pki(2, 0, 0, 0), 1'b0);
    push_exp(4'b0001, pk(7, 0, 0, 0), pki(6, 0, 0, 0), 1'b1);
    push_nnz(7);
    @(posedge clk); #1;
    fork
      begin
        send(pk(1, 2, 3, 4), 1'b0, w);
        chk("stall_w1", 64'(w), 64'd0);
        send(pk(0, 5, 0, 0), 1'b0, w2);
        chk("stall_w2", 64'(w2), 64'd3);
        send(pk(6, 0, 0, 0), 1'b0, w);
        chk("resume_w3", 64'(w), 64'd0);
        send(pk(0, 0, 0, 7), 1'b1, w);
        chk("resume_w4", 64'(w), 64'd0);
      end
      begin
        @(posedge clk); #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_in_ready", 64'(in_ready), 64'd0);
          chk("hold_mask", 64'(out_mask), 64'hf);
          chk("hold_data", out_data, pk(1, 2, 3, 4));
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-plane with a carried run of 2
    push_exp(4'b0001, pk(3, 0, 0, 0), pki(1, 0, 0, 0), 1'b0);
    send(pk(0, 3, 0, 0), 1'b0, w);
    drain();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    push_exp(4'b0001, pk(8, 0, 0, 0), pki(1, 0, 0, 0), 1'b1);
    push_nnz(1);
    send(pk(0, 8, 0, 0), 1'b1, w);
    drain();

    // Randomized sparse traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          for (int k = 0; k < 4; k++)
            d[k*16 +: 16] = ($urandom_range(0, 9) < 7) ? 16'h0 : 16'($urandom);
          l = (i == 59) || ($urandom_range(0, 6) == 0);
          model_beat(d, l);
          send(d, l, w);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("plane_done_count", 64'(done_seen), 64'(planes_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
